// File: rtl/ram_pkg.sv
// Shared defaults and FSM state encoding for the RAM burst master.
package ram_pkg;

  localparam int RAM_DATA_W = 8;   // RAM word width
  localparam int RAM_ADDR_W = 6;   // RAM address port width
  localparam int RAM_DEPTH  = 32;  // implemented words, power of two
  localparam int RAM_LEN_W  = 5;   // burst length field, beats = len + 1

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_FILL = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/ram_burst_addr_gen.sv
// Burst address generator: loadable address register that wraps modulo DEPTH,
// plus a beat down-counter flagging the final beat. The address register is
// kept at full port width but masked, so bits above the implemented depth are
// always zero on the RAM port.
module ram_burst_addr_gen
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH,
  parameter int LEN_W  = RAM_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              last_beat_o
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_inc_s;

  assign addr_inc_s  = (addr_q + {{(ADDR_W-1){1'b0}}, 1'b1}) & ADDR_MASK;
  assign cur_addr_o  = addr_q;
  assign next_addr_o = addr_inc_s;
  assign last_beat_o = (cnt_q == {LEN_W{1'b0}});

  // Next-state: load on request accept, step address and count on each beat.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = start_addr_i & ADDR_MASK;
      cnt_d  = len_i;
    end else if (advance_i) begin
      addr_d = addr_inc_s;
      if (cnt_q != {LEN_W{1'b0}}) begin
        cnt_d = cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
    end
  end

  // Address and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= {ADDR_W{1'b0}};
      cnt_q  <= {LEN_W{1'b0}};
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst master for a single-port synchronous RAM with a registered read
// address. Write beats go straight to the RAM port; reads use one fill cycle
// to prime the RAM address register, then stream one beat per cycle. Under
// read backpressure the address is held so the RAM output stays stable,
// which removes the need for a skid buffer.
module ram_burst_master
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH,
  parameter int LEN_W  = RAM_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_e            state_q, state_d;
  logic              load_s;
  logic              advance_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic              last_beat_s;

  ram_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load_s),
    .advance_i    (advance_s),
    .start_addr_i (req_addr),
    .len_i        (req_len),
    .cur_addr_o   (cur_addr_s),
    .next_addr_o  (next_addr_s),
    .last_beat_o  (last_beat_s)
  );

  // State register; reset returns to IDLE so ram_we drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and port drive; every output defaults to its idle value.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = {DATA_W{1'b0}};
    done        = 1'b0;
    ram_addr    = {ADDR_W{1'b0}};
    ram_data_in = {DATA_W{1'b0}};
    ram_we      = 1'b0;
    load_s      = 1'b0;
    advance_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load_s  = 1'b1;
          state_d = req_write ? ST_WR : ST_RD_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        wr_ready    = 1'b1;
        ram_addr    = cur_addr_s;
        ram_data_in = wr_data;
        ram_we      = wr_valid;
        if (wr_valid) begin
          advance_s = 1'b1;
          state_d   = last_beat_s ? ST_DONE : ST_WR;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RD_FILL: begin
        // RAM captures the first read address at the end of this cycle.
        ram_addr = cur_addr_s;
        state_d  = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        rd_valid = 1'b1;
        rd_data  = ram_data_out;
        if (rd_ready) begin
          // Present the next address now so its data appears next cycle.
          ram_addr  = next_addr_s;
          advance_s = 1'b1;
          state_d   = last_beat_s ? ST_DONE : ST_RD_DATA;
        end else begin
          ram_addr = cur_addr_s;
          state_d  = ST_RD_DATA;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural single-port RAM
// (registered read address) attached to the RAM-side ports.
module tb_ram_burst_master;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [5:0] req_addr;
  logic [4:0] req_len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       done;
  logic [5:0] ram_addr;
  logic [7:0] ram_data_in;
  logic       ram_we;
  logic [7:0] ram_data_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [64] = '{default: 8'h00};
  logic [5:0] ram_addr_r = 6'd0;

  ram_burst_master dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .done         (done),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_we       (ram_we),
    .ram_data_out (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, registered read address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    ram_addr_r <= ram_addr;
  end
  assign ram_data_out = mem[ram_addr_r];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 6'd0;
    req_len   = 5'd0;
    wr_valid  = 1'b0;
    wr_data   = 8'h00;
    rd_ready  = 1'b0;
  endtask

  // Present a request for one cycle; the controller must be ready for it.
  task automatic issue(input logic w, input logic [5:0] a, input logic [4:0] l);
    @(negedge clk);
    idle_inputs();
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    #1 check("req_ready_accept", {31'd0, req_ready}, 32'd1);
  endtask

  // Read fill cycle: no data yet, start address on the RAM port.
  task automatic fill_cycle(input logic [5:0] exp_addr);
    @(negedge clk);
    idle_inputs();
    rd_ready = 1'b1;
    #1;
    check("fill_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("fill_ram_addr", {26'd0, ram_addr}, {26'd0, exp_addr});
  endtask

  // One-cycle done pulse followed by a return to IDLE.
  task automatic expect_done(input string tag);
    @(negedge clk);
    idle_inputs();
    #1;
    check({tag, "_done_hi"}, {31'd0, done}, 32'd1);
    check({tag, "_done_req_ready"}, {31'd0, req_ready}, 32'd0);
    check({tag, "_done_we"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_done_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_done_lo"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  logic [7:0] a_dat [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
  logic [7:0] b_dat [4] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
  logic       bp_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] bp_dat [7] = '{8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3};
  logic [5:0] bp_adr [7] = '{6'd4, 6'd4, 6'd4, 6'd4, 6'd5, 6'd6, 6'd0};
  logic       wg_vld [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] wg_dat [6] = '{8'hB0, 8'hEE, 8'hB1, 8'hB2, 8'hEE, 8'hB3};
  logic [5:0] wg_adr [6] = '{6'd30, 6'd31, 6'd31, 6'd0, 6'd1, 6'd1};

  // Directed sequence.
  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted while idle.
    rst = 1'b1;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {26'd0, ram_addr}, 32'd0);
    check("rst_ram_data_in", {24'd0, ram_data_in}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write burst: addr 3, four back-to-back beats.
    issue(1'b1, 6'd3, 5'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      wr_valid = 1'b1;
      wr_data  = a_dat[i];
      #1;
      check("wr_ready", {31'd0, wr_ready}, 32'd1);
      check("wr_we", {31'd0, ram_we}, 32'd1);
      check("wr_addr", {26'd0, ram_addr}, 32'(3 + i));
      check("wr_data_in", {24'd0, ram_data_in}, {24'd0, a_dat[i]});
    end
    expect_done("wr");
    for (int i = 0; i < 4; i++) check("wr_mem", {24'd0, mem[3 + i]}, {24'd0, a_dat[i]});

    // Read burst: addr 3, no backpressure.
    issue(1'b0, 6'd3, 5'd3);
    fill_cycle(6'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      rd_ready = 1'b1;
      #1;
      check("rd_valid", {31'd0, rd_valid}, 32'd1);
      check("rd_data", {24'd0, rd_data}, {24'd0, a_dat[i]});
    end
    expect_done("rd");

    // Read burst with a three-cycle stall on beat 1.
    issue(1'b0, 6'd3, 5'd3);
    fill_cycle(6'd3);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      idle_inputs();
      rd_ready = bp_rdy[i];
      #1;
      check("bp_rd_valid", {31'd0, rd_valid}, 32'd1);
      check("bp_rd_data", {24'd0, rd_data}, {24'd0, bp_dat[i]});
      if (i < 6) check("bp_ram_addr", {26'd0, ram_addr}, {26'd0, bp_adr[i]});
    end
    expect_done("bp");

    // Write across the wrap point with gaps in wr_valid.
    issue(1'b1, 6'd30, 5'd3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_inputs();
      wr_valid = wg_vld[i];
      wr_data  = wg_dat[i];
      #1;
      check("wg_wr_ready", {31'd0, wr_ready}, 32'd1);
      check("wg_we", {31'd0, ram_we}, {31'd0, wg_vld[i]});
      check("wg_addr", {26'd0, ram_addr}, {26'd0, wg_adr[i]});
    end
    expect_done("wg");
    check("wg_mem30", {24'd0, mem[30]}, 32'hB0);
    check("wg_mem31", {24'd0, mem[31]}, 32'hB1);
    check("wg_mem0", {24'd0, mem[0]}, 32'hB2);
    check("wg_mem1", {24'd0, mem[1]}, 32'hB3);
    check("wg_mem2", {24'd0, mem[2]}, 32'h00);
    check("wg_mem32", {24'd0, mem[32]}, 32'h00);

    // Readback from 62: upper address bit ignored, lands on 30.
    issue(1'b0, 6'd62, 5'd3);
    fill_cycle(6'd30);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      rd_ready = 1'b1;
      #1;
      check("wrap_rd_valid", {31'd0, rd_valid}, 32'd1);
      check("wrap_rd_data", {24'd0, rd_data}, {24'd0, b_dat[i]});
    end
    expect_done("wrap");

    // Reset during beat 2 of a write burst from addr 0.
    issue(1'b1, 6'd0, 5'd3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle_inputs();
      wr_valid = 1'b1;
      wr_data  = 8'(8'hC0 + i);
      #1 check("mid_addr", {26'd0, ram_addr}, 32'(i));
    end
    @(negedge clk);
    idle_inputs();
    wr_valid = 1'b1;
    wr_data  = 8'hC2;
    #1 check("mid_we_before_rst", {31'd0, ram_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_we_in_rst", {31'd0, ram_we}, 32'd0);
    check("mid_wr_ready_in_rst", {31'd0, wr_ready}, 32'd0);
    check("mid_req_ready_in_rst", {31'd0, req_ready}, 32'd1);
    check("mid_addr_in_rst", {26'd0, ram_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1 check("mid_idle_ready", {31'd0, req_ready}, 32'd1);
    check("mid_mem0", {24'd0, mem[0]}, 32'hC0);
    check("mid_mem1", {24'd0, mem[1]}, 32'hC1);
    check("mid_mem2", {24'd0, mem[2]}, 32'h00);
    check("mid_mem3", {24'd0, mem[3]}, 32'hA0);

    // Single-beat read after recovery.
    issue(1'b0, 6'd0, 5'd0);
    fill_cycle(6'd0);
    @(negedge clk);
    idle_inputs();
    rd_ready = 1'b1;
    #1;
    check("post_rd_valid", {31'd0, rd_valid}, 32'd1);
    check("post_rd_data", {24'd0, rd_data}, 32'hC0);
    expect_done("post");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
